// File: rtl/logic_box_cfg_pkg.sv
// Shared constants and FSM encoding for the Logic_box serial configuration loader.
// Frame layout: SYNC | ADDR | PAYLOAD [| PARITY when CFG_PARITY_EN is defined].
package logic_box_cfg_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam logic [7:0] ACTIVATE_ADDR = 8'hFF;
    localparam int         PAYLOAD_W     = 23;

    // Payload = {lut[15:0], sel, sel_direction[1:0], sel_direction_BLEout[3:0]}
    localparam int LUT_LSB    = 7;
    localparam int SEL_BIT    = 6;
    localparam int DIR_LSB    = 4;
    localparam int BLEOUT_LSB = 0;

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_COMMIT = 3'd4
    } cfg_state_t;

endpackage

// File: rtl/cfg_frame_deserializer.sv
// Serial frame deframer: sync hunt, address/payload shift registers and optional even parity.
// CFG_PARITY_EN adds a trailing parity bit over ADDR+PAYLOAD.
module cfg_frame_deserializer
    import logic_box_cfg_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_bit,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 commit_pulse,
    output logic [ADDR_W-1:0]    addr,
    output logic [PAYLOAD_W-1:0] payload,
    output logic                 parity_ok
);

    cfg_state_t             state_reg, state_next;
    logic [7:0]             window_reg, window_next;
    logic [4:0]             bit_cnt_reg, bit_cnt_next;
    logic [ADDR_W-1:0]      addr_reg, addr_next;
    logic [PAYLOAD_W-1:0]   payload_reg, payload_next;
    logic                   accept;
`ifdef CFG_PARITY_EN
    logic                   parity_acc_reg, parity_acc_next;
    logic                   parity_ok_reg, parity_ok_next;
`endif

    // The commit cycle is the only cycle in which input is refused.
    assign accept = cfg_valid && (state_reg != ST_COMMIT);

    always_comb begin
        state_next   = state_reg;
        window_next  = window_reg;
        bit_cnt_next = bit_cnt_reg;
        addr_next    = addr_reg;
        payload_next = payload_reg;
`ifdef CFG_PARITY_EN
        parity_acc_next = parity_acc_reg;
        parity_ok_next  = parity_ok_reg;
`endif
        case (state_reg)
            ST_HUNT: begin
                if (accept) begin
                    window_next = {window_reg[6:0], cfg_bit};
                    if (window_next == SYNC_BYTE) begin
                        state_next   = ST_ADDR;
                        bit_cnt_next = '0;
`ifdef CFG_PARITY_EN
                        parity_acc_next = 1'b0;
`endif
                    end
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    addr_next = {addr_reg[ADDR_W-2:0], cfg_bit};
`ifdef CFG_PARITY_EN
                    parity_acc_next = parity_acc_reg ^ cfg_bit;
`endif
                    if (bit_cnt_reg == 5'(ADDR_W - 1)) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    payload_next = {payload_reg[PAYLOAD_W-2:0], cfg_bit};
`ifdef CFG_PARITY_EN
                    parity_acc_next = parity_acc_reg ^ cfg_bit;
`endif
                    if (bit_cnt_reg == 5'(PAYLOAD_W - 1)) begin
                        bit_cnt_next = '0;
`ifdef CFG_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_COMMIT;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end
            end
`ifdef CFG_PARITY_EN
            ST_PARITY: begin
                if (accept) begin
                    // Even parity: all 32 bits must XOR to zero.
                    parity_ok_next = ~(parity_acc_reg ^ cfg_bit);
                    state_next     = ST_COMMIT;
                end
            end
`endif
            ST_COMMIT: begin
                state_next  = ST_HUNT;
                window_next = '0;
            end
            default: begin
                state_next  = ST_HUNT;
                window_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_HUNT;
            window_reg  <= '0;
            bit_cnt_reg <= '0;
            addr_reg    <= '0;
            payload_reg <= '0;
`ifdef CFG_PARITY_EN
            parity_acc_reg <= 1'b0;
            parity_ok_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            window_reg  <= window_next;
            bit_cnt_reg <= bit_cnt_next;
            addr_reg    <= addr_next;
            payload_reg <= payload_next;
`ifdef CFG_PARITY_EN
            parity_acc_reg <= parity_acc_next;
            parity_ok_reg  <= parity_ok_next;
`endif
        end
    end

    assign cfg_ready    = (state_reg != ST_COMMIT);
    assign commit_pulse = (state_reg == ST_COMMIT);
    assign addr         = addr_reg;
    assign payload      = payload_reg;
`ifdef CFG_PARITY_EN
    assign parity_ok    = parity_ok_reg;
`else
    assign parity_ok    = 1'b1;
`endif

endmodule

// File: rtl/logic_box_config_loader.sv
// Double-buffered serial config writer for a column of Logic_box tiles; shadows fill per frame,
// an ACTIVATE frame copies all shadows to live outputs at once. CFG_PARITY_EN enables frame parity.
module logic_box_config_loader
    import logic_box_cfg_pkg::*;
#(
    parameter int NUM_BOXES = 4,
    parameter int ADDR_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_bit,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic [16*NUM_BOXES-1:0] lut_out,
    output logic [NUM_BOXES-1:0]    sel_out,
    output logic [2*NUM_BOXES-1:0]  sel_direction_out,
    output logic [4*NUM_BOXES-1:0]  sel_dir_bleout_out,
    output logic                   cfg_wr_ack,
    output logic                   cfg_done,
    output logic                   cfg_error
);

    logic                 commit_pulse;
    logic [ADDR_W-1:0]    frame_addr;
    logic [PAYLOAD_W-1:0] frame_payload;
    logic                 parity_ok;
    logic                 wr_en, activate, bad_frame;

    cfg_frame_deserializer #(
        .ADDR_W(ADDR_W)
    ) u_deser (
        .clk          (clk),
        .reset        (reset),
        .cfg_bit      (cfg_bit),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .commit_pulse (commit_pulse),
        .addr         (frame_addr),
        .payload      (frame_payload),
        .parity_ok    (parity_ok)
    );

    assign wr_en     = commit_pulse && parity_ok && (int'(frame_addr) < NUM_BOXES);
    assign activate  = commit_pulse && parity_ok && (frame_addr == ADDR_W'(ACTIVATE_ADDR));
    assign bad_frame = commit_pulse && !wr_en && !activate;

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_wr_ack <= 1'b0;
            cfg_error  <= 1'b0;
            cfg_done   <= 1'b0;
        end else begin
            cfg_wr_ack <= wr_en;
            cfg_error  <= bad_frame;
            if (activate) begin
                cfg_done <= 1'b1;
            end
        end
    end

    // Per-tile shadow/live pair; live only moves on ACTIVATE so running fabric is never disturbed.
    generate
        for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_box
            logic [PAYLOAD_W-1:0] shadow_reg;
            logic [PAYLOAD_W-1:0] live_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_reg <= '0;
                    live_reg   <= '0;
                end else begin
                    if (wr_en && (frame_addr == ADDR_W'(gi))) begin
                        shadow_reg <= frame_payload;
                    end
                    if (activate) begin
                        live_reg <= shadow_reg;
                    end
                end
            end

            assign lut_out[16*gi +: 16]           = live_reg[LUT_LSB +: 16];
            assign sel_out[gi]                    = live_reg[SEL_BIT];
            assign sel_direction_out[2*gi +: 2]   = live_reg[DIR_LSB +: 2];
            assign sel_dir_bleout_out[4*gi +: 4]  = live_reg[BLEOUT_LSB +: 4];
        end
    endgenerate

endmodule
